// File: rtl/xor_gate_pkg.sv
// Shared constants and mode encoding for the xor_gate block.
// Holds default widths and the XOR/XNOR mode enum selected by INVERT.
// No logic; imported by the top and the edge detector.
package xor_gate_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    MODE_XOR  = 1'b0,
    MODE_XNOR = 1'b1
  } mode_e;

  // Maps the integer INVERT parameter onto the mode enum.
  function automatic mode_e mode_from_invert(input int invert);
    return (invert != 0) ? MODE_XNOR : MODE_XOR;
  endfunction

endpackage

// File: rtl/xor_gate_edge_det.sv
// Per-bit rising/falling edge detector on a registered input vector.
// Ports: clk, rst_n (async active-low), d (vector to watch), rise/fall (one-cycle pulses).
// Pulses are valid in the cycle d holds its new value; no backpressure.
module xor_gate_edge_det
  import xor_gate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // One-cycle-delayed copy of d. Its reset value of 0 acts as the prior
  // state, so a 1 captured right after reset shows up as a rising edge.
  logic [WIDTH-1:0] d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '0;
    end else begin
      d_q <= d;
    end
  end

  // d is itself a register output, so these are glitch-free and both
  // collapse to 0 the moment reset clears d and d_q.
  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/xor_gate.sv
// Bitwise XOR/XNOR with a registered copy, per-bit edge pulses and a saturating toggle counter.
// Ports: clk, rst_n, a, b, clr in; y (combinational), y_q (1 cycle), y_rise/y_fall, toggle_cnt out.
// y has zero latency; y_q one cycle; toggle_cnt counts cycles with any edge pulse, clr wins.
module xor_gate
  import xor_gate_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int INVERT = 0,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [WIDTH-1:0] y_rise,
  output logic [WIDTH-1:0] y_fall,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam mode_e            MODE    = mode_from_invert(INVERT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic any_edge;

  // Pure function of a and b: unaffected by clk, rst_n or clr.
  assign y = (MODE == MODE_XNOR) ? ~(a ^ b) : (a ^ b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y;
    end
  end

  xor_gate_edge_det #(
    .WIDTH (WIDTH)
  ) u_edge_det (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (y_q),
    .rise  (y_rise),
    .fall  (y_fall)
  );

  assign any_edge = |(y_rise | y_fall);

  // Saturating counter; clr takes priority over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_cnt <= '0;
    end else if (clr) begin
      toggle_cnt <= '0;
    end else if (any_edge && (toggle_cnt != CNT_MAX)) begin
      toggle_cnt <= toggle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_xor_gate.sv
// Bench for xor_gate: three instances (1-bit XOR, 1-bit XNOR, 4-bit XOR with 2-bit counter).
// Directed scenarios plus randomized traffic on the 4-bit instance against a reference model.
// Prints one summary line and finishes.
module tb_xor_gate;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 1-bit XOR and XNOR instances share operands
  logic        a0, b0, clr0;
  logic        y0, yq0, r0, f0;
  logic [15:0] c0;
  logic        y1, yq1, r1, f1;
  logic [15:0] c1;

  // 4-bit XOR instance with a 2-bit counter
  logic [3:0] a4, b4, y4, yq4, r4, f4;
  logic       clr4;
  logic [1:0] c4;

  int checks   = 0;
  int failures = 0;

  xor_gate #(.WIDTH(1), .INVERT(0), .CNT_W(16)) u_xor1 (
    .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .clr(clr0),
    .y(y0), .y_q(yq0), .y_rise(r0), .y_fall(f0), .toggle_cnt(c0));

  xor_gate #(.WIDTH(1), .INVERT(1), .CNT_W(16)) u_xnor1 (
    .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .clr(clr0),
    .y(y1), .y_q(yq1), .y_rise(r1), .y_fall(f1), .toggle_cnt(c1));

  xor_gate #(.WIDTH(4), .INVERT(0), .CNT_W(2)) u_xor4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .clr(clr4),
    .y(y4), .y_q(yq4), .y_rise(r4), .y_fall(f4), .toggle_cnt(c4));

  // Reference model of the 4-bit instance: the value sampled at the last
  // edge, the one before it, and a change counter capped at 3.
  logic [3:0] m_yq, m_prev;
  int         m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_yq   <= 4'h0;
      m_prev <= 4'h0;
      m_cnt  <= 0;
    end else begin
      if (clr4)
        m_cnt <= 0;
      else if (m_yq != m_prev)
        m_cnt <= (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
      m_prev <= m_yq;
      m_yq   <= a4 ^ b4;
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    clr4  = 1'b0;
    a4    = 4'h0;
    b4    = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    a4 = 4'b1001;
    b4 = 4'b0011;
    #1;
    checks++; if (y4 !== 4'b1010) begin failures++; $display("FAIL reset_y_tracks got=%b exp=%b", y4, 4'b1010); end
    checks++; if (yq4 !== 4'h0) begin failures++; $display("FAIL reset_yq got=%b exp=0000", yq4); end
    checks++; if (r4 !== 4'h0 || f4 !== 4'h0) begin failures++; $display("FAIL reset_edges rise=%b fall=%b exp=0000", r4, f4); end
    checks++; if (c4 !== 2'd0 || c0 !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0", c4, c0); end
    a4 = 4'h0;
    b4 = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table;
    logic [3:0] xt;
    logic [3:0] xnt;
    xt  = 4'b0110;
    xnt = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      {a0, b0} = i[1:0];
      #10;
      checks++; if (y0 !== xt[i]) begin failures++; $display("FAIL truth_xor ab=%0d got=%b exp=%b", i, y0, xt[i]); end
      checks++; if (y1 !== xnt[i]) begin failures++; $display("FAIL truth_xnor ab=%0d got=%b exp=%b", i, y1, xnt[i]); end
    end
  endtask

  task automatic test_directed_w4;
    do_reset();
    a4 = 4'b1100;
    b4 = 4'b1010;
    #1;
    checks++; if (y4 !== 4'b0110) begin failures++; $display("FAIL dir_y got=%b exp=0110", y4); end
    @(posedge clk); #1;
    checks++; if (yq4 !== 4'b0110) begin failures++; $display("FAIL dir_yq got=%b exp=0110", yq4); end
    checks++; if (r4 !== 4'b0110 || f4 !== 4'b0000) begin failures++; $display("FAIL dir_rise rise=%b fall=%b exp=0110/0000", r4, f4); end
    checks++; if (c4 !== 2'd0) begin failures++; $display("FAIL dir_cnt0 got=%0d exp=0", c4); end
    @(posedge clk); #1;
    checks++; if (r4 !== 4'b0000) begin failures++; $display("FAIL dir_rise_once got=%b exp=0000", r4); end
    checks++; if (c4 !== 2'd1) begin failures++; $display("FAIL dir_cnt1 got=%0d exp=1", c4); end
    @(negedge clk);
    a4 = 4'h0;
    b4 = 4'h0;
    @(posedge clk); #1;
    checks++; if (f4 !== 4'b0110 || r4 !== 4'b0000) begin failures++; $display("FAIL dir_fall rise=%b fall=%b exp=0000/0110", r4, f4); end
  endtask

  task automatic test_saturation;
    int sat_tab[6];
    sat_tab = '{0, 1, 2, 3, 3, 3};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a4 = (k % 2 == 0) ? 4'hF : 4'h0;
      b4 = 4'h0;
      @(posedge clk); #1;
      checks++; if (c4 !== sat_tab[k][1:0] || m_cnt != sat_tab[k]) begin failures++; $display("FAIL sat_cnt step=%0d got=%0d exp=%0d", k, c4, sat_tab[k]); end
    end
    // Toggle pending plus clr in the same cycle: clear wins.
    @(negedge clk);
    a4   = ~a4;
    clr4 = 1'b1;
    @(posedge clk); #1;
    checks++; if (c4 !== 2'd0) begin failures++; $display("FAIL clr_priority got=%0d exp=0", c4); end
    @(negedge clk);
    clr4 = 1'b0;
    @(posedge clk); #1;
    checks++; if (c4 !== 2'd1) begin failures++; $display("FAIL clr_resume got=%0d exp=1", c4); end
  endtask

  task automatic test_random;
    logic [3:0] er, ef;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      a4   = 4'($urandom);
      b4   = 4'($urandom);
      clr4 = ($urandom_range(0, 9) == 0);
      #1;
      checks++; if (y4 !== (a4 ^ b4)) begin failures++; $display("FAIL rnd_y n=%0d got=%b exp=%b", n, y4, a4 ^ b4); end
      @(posedge clk); #1;
      er = m_yq & ~m_prev;
      ef = ~m_yq & m_prev;
      checks++; if (yq4 !== m_yq) begin failures++; $display("FAIL rnd_yq n=%0d got=%b exp=%b", n, yq4, m_yq); end
      checks++; if (r4 !== er || f4 !== ef) begin failures++; $display("FAIL rnd_edges n=%0d rise=%b/%b fall=%b/%b", n, r4, er, f4, ef); end
      checks++; if (c4 !== m_cnt[1:0]) begin failures++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, c4, m_cnt); end
      checks++; if ((r4 & f4) !== 4'h0) begin failures++; $display("FAIL rnd_exclusive n=%0d rise=%b fall=%b", n, r4, f4); end
    end
    clr4 = 1'b0;
  endtask

  task automatic test_glitch;
    @(negedge clk);
    a4 = 4'h3;
    b4 = 4'h0;
    @(posedge clk); #2;
    a4 = 4'hC;
    #1;
    checks++; if (y4 !== 4'hC) begin failures++; $display("FAIL glitch_visible got=%h exp=c", y4); end
    #1;
    a4 = 4'h3;
    @(posedge clk); #1;
    checks++; if (yq4 !== 4'h3 || yq4 !== m_yq) begin failures++; $display("FAIL glitch_ignored got=%h exp=3", yq4); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    a0 = 1'b1;
    b0 = 1'b0;
    @(posedge clk); #1;
    checks++; if (yq0 !== 1'b1) begin failures++; $display("FAIL mid_pre_yq got=%b exp=1", yq0); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (yq0 !== 1'b0 || r0 !== 1'b0 || f0 !== 1'b0) begin failures++; $display("FAIL mid_clear yq=%b rise=%b fall=%b exp=0", yq0, r0, f0); end
    checks++; if (c0 !== 16'd0 || c4 !== 2'd0 || yq4 !== 4'h0) begin failures++; $display("FAIL mid_clear_cnt c0=%0d c4=%0d yq4=%h exp=0", c0, c4, yq4); end
    b0 = 1'b1;
    #1;
    checks++; if (y0 !== 1'b0 || y1 !== 1'b1) begin failures++; $display("FAIL mid_y_tracks xor=%b xnor=%b exp=0/1", y0, y1); end
    b0 = 1'b0;
    #1;
    checks++; if (y0 !== 1'b1) begin failures++; $display("FAIL mid_y_tracks2 got=%b exp=1", y0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    a0 = 1'b0; b0 = 1'b0; clr0 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; clr4 = 1'b0;
    #1;
    rst_n = 1'b0;
    test_reset();
    test_truth_table();
    test_directed_w4();
    test_saturation();
    test_random();
    test_glitch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
